// File: rtl/boot_loader_if.sv
// ---------------------------------------------------------------------------
// boot_loader_if
// Groups the byte-stream handshake, the data_mem write port and the loader
// control/status lines between boot_loader and its environment.
//   master : boot_loader side (accepts stream bytes, drives memory port/status)
//   slave  : environment side (byte source, load request, memory/CPU sink)
// Signals:
//   load_req       start-load pulse            (env -> loader)
//   rx_valid/data  stream byte offer           (env -> loader)
//   rx_ready       loader accepts byte         (loader -> env)
//   Ext_MemWrite   1-cycle word write strobe   (loader -> data_mem)
//   Ext_WriteData  word to write               (loader -> data_mem)
//   Ext_DataAdr    byte address of word        (loader -> data_mem)
//   cpu_reset      active-high CPU reset       (loader -> pl_riscv_cpu)
//   load_busy/done/err, word_cnt  status       (loader -> env)
// ---------------------------------------------------------------------------
interface boot_loader_if;
  logic        load_req;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        Ext_MemWrite;
  logic [31:0] Ext_WriteData;
  logic [31:0] Ext_DataAdr;
  logic        cpu_reset;
  logic        load_busy;
  logic        load_done;
  logic        load_err;
  logic [15:0] word_cnt;

  modport master (
    input  load_req, rx_valid, rx_data,
    output rx_ready, Ext_MemWrite, Ext_WriteData, Ext_DataAdr,
           cpu_reset, load_busy, load_done, load_err, word_cnt
  );

  modport slave (
    output load_req, rx_valid, rx_data,
    input  rx_ready, Ext_MemWrite, Ext_WriteData, Ext_DataAdr,
           cpu_reset, load_busy, load_done, load_err, word_cnt
  );
endinterface

// File: rtl/boot_loader.sv
// ---------------------------------------------------------------------------
// boot_loader
// Byte-stream program loader in front of pl_riscv_cpu. Receives a
// little-endian stream (len_lo, len_hi, then 4*N data bytes), packs the bytes
// into 32-bit words, writes them to data_mem through the Ext_* port and holds
// the CPU in reset until the image is complete.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    boot_loader_if.master (stream handshake, memory port, status)
// Parameters:
//   BASE_ADDR    byte address of the first written word
//   MAX_WORDS    largest accepted image length in words (<= 65535)
//   RELEASE_CYC  cycles cpu_reset is held after the image is complete (>= 1)
// Build option:
//   BOOT_LOADER_CHECKSUM_EN  adds a trailing checksum byte; the 8-bit sum of
//                            all stream bytes including it must be 8'h00.
// ---------------------------------------------------------------------------
module boot_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MAX_WORDS   = 1024,
  parameter int unsigned RELEASE_CYC = 4
) (
  input  logic          clk,
  input  logic          reset,
  boot_loader_if.master bus
);

  // state   | meaning
  // IDLE    | after reset, waiting for load_req
  // LEN0    | waiting for length low byte
  // LEN1    | waiting for length high byte, range check
  // DATA    | collecting the 4 bytes of a word
  // WRITE   | one-cycle write strobe of the assembled word
  // CSUM    | waiting for checksum byte (checksum build only)
  // RELEASE | image complete, CPU still held in reset
  // RUN     | CPU released
  // ERR     | bad length or checksum, CPU held in reset
  typedef enum logic [3:0] {
    IDLE, LEN0, LEN1, DATA, WRITE, RELEASE, RUN, ERR
`ifdef BOOT_LOADER_CHECKSUM_EN
    , CSUM
`endif
  } stateT;

  localparam logic [15:0]      MAX_LEN  = 16'(MAX_WORDS);
  localparam int               RC_W     = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
  localparam logic [RC_W-1:0]  REL_LOAD = RC_W'(RELEASE_CYC - 1);

`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam stateT TAIL = CSUM;
`else
  localparam stateT TAIL = RELEASE;
`endif

  stateT           state, nextState;
  logic [15:0]     lenReg;
  logic [15:0]     wordCnt;
  logic [1:0]      byteIdx;
  logic [23:0]     wordBuf;
  logic [31:0]     wrData;
  logic [31:0]     wrAdr;
  logic [RC_W-1:0] relCnt;
  logic            loadDone;
  logic            rxReady;
  logic            take;
  logic            startLoad;
  logic [15:0]     lenFull;

  assign take      = bus.rx_valid & rxReady;
  assign lenFull   = {bus.rx_data, lenReg[7:0]};
  assign startLoad = bus.load_req & ((state == IDLE) | (state == RUN) | (state == ERR));

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0] csumAcc;
  logic [7:0] csumNext;
  assign csumNext = csumAcc + bus.rx_data;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      lenReg   <= '0;
      wordCnt  <= '0;
      byteIdx  <= '0;
      wordBuf  <= '0;
      wrData   <= '0;
      wrAdr    <= '0;
      relCnt   <= '0;
      loadDone <= 1'b0;
    end else begin
      state <= nextState;

      if (startLoad) begin
        wordCnt <= '0;
        byteIdx <= '0;
      end

      if (take && (state == LEN0)) lenReg[7:0]  <= bus.rx_data;
      if (take && (state == LEN1)) lenReg[15:8] <= bus.rx_data;

      // Bytes shift in from the top so that after three of them wordBuf
      // holds {b2, b1, b0} and the fourth completes the word directly.
      if (take && (state == DATA)) begin
        byteIdx <= byteIdx + 2'd1;
        wordBuf <= {bus.rx_data, wordBuf[23:8]};
        if (byteIdx == 2'd3) begin
          wrData <= {bus.rx_data, wordBuf};
          wrAdr  <= BASE_ADDR + {14'd0, wordCnt, 2'b00};
        end
      end

      if (state == WRITE) wordCnt <= wordCnt + 16'd1;

      // Release timer: loaded on entry, terminal count at zero.
      if ((nextState == RELEASE) && (state != RELEASE)) begin
        relCnt <= REL_LOAD;
      end else if ((state == RELEASE) && (relCnt != '0)) begin
        relCnt <= relCnt - RC_W'(1);
      end

      loadDone <= (state == RELEASE) && (relCnt == '0);
    end
  end

`ifdef BOOT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csumAcc <= '0;
    end else if (startLoad) begin
      csumAcc <= '0;
    end else if (take) begin
      csumAcc <= csumNext;
    end
  end
`endif

  always_comb begin
    nextState = state;
    rxReady   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load_req) nextState = LEN0;
      end
      LEN0: begin
        rxReady = 1'b1;
        if (bus.rx_valid) nextState = LEN1;
      end
      LEN1: begin
        rxReady = 1'b1;
        if (bus.rx_valid) begin
          if (lenFull == 16'd0)        nextState = TAIL;
          else if (lenFull > MAX_LEN)  nextState = ERR;
          else                         nextState = DATA;
        end
      end
      DATA: begin
        rxReady = 1'b1;
        if (bus.rx_valid && (byteIdx == 2'd3)) nextState = WRITE;
      end
      WRITE: begin
        nextState = ((wordCnt + 16'd1) == lenReg) ? TAIL : DATA;
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      CSUM: begin
        rxReady = 1'b1;
        if (bus.rx_valid) nextState = (csumNext == 8'h00) ? RELEASE : ERR;
      end
`endif
      RELEASE: begin
        if (relCnt == '0) nextState = RUN;
      end
      RUN: begin
        if (bus.load_req) nextState = LEN0;
      end
      ERR: begin
        if (bus.load_req) nextState = LEN0;
      end
      default: nextState = IDLE;
    endcase
  end

  assign bus.rx_ready      = rxReady;
  assign bus.Ext_MemWrite  = (state == WRITE);
  assign bus.Ext_WriteData = wrData;
  assign bus.Ext_DataAdr   = wrAdr;
  // A reload request from RUN puts the CPU back into reset in the same cycle
  // rather than one cycle later when LEN0 is reached.
  assign bus.cpu_reset     = (state != RUN) | bus.load_req;
  assign bus.load_busy     = !((state == IDLE) || (state == RUN) || (state == ERR));
  assign bus.load_done     = loadDone;
  assign bus.load_err      = (state == ERR);
  assign bus.word_cnt      = wordCnt;

endmodule
